// File: rtl/reflex_pkg.sv
`default_nettype none
// ============================================================================
// reflex_pkg : shared types and constants for the reflex-test sequencer.
// Rev 1.0
// ============================================================================
package reflex_pkg;

  localparam int               c_ms_w      = 14;
  localparam logic [c_ms_w-1:0] c_ms_none  = 14'h3FFF;
  localparam logic [15:0]      c_lfsr_seed = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0]      c_lfsr_taps = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_SYNC   = 3'd2,
    ST_STIM   = 3'd3,
    ST_RESULT = 3'd4
  } state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & c_lfsr_taps)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ms_timer.sv
`default_nettype none
// ============================================================================
// ms_timer : clk-to-millisecond prescaler with a saturating ms counter.
// Rev 1.0
// ============================================================================
module ms_timer
  import reflex_pkg::*;
#(
  parameter int MS_DIV = 25000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  output logic              tick_o,
  output logic [c_ms_w-1:0] count_o
);

  localparam int              c_pw         = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [c_pw-1:0] c_presc_last = c_pw'(MS_DIV - 1);

  logic [c_pw-1:0]   presc_q, presc_d;
  logic [c_ms_w-1:0] count_q, count_d;

  assign tick_o  = (presc_q == c_presc_last);
  assign count_o = count_q;

  always_comb begin
    presc_d = tick_o ? '0 : presc_q + 1'b1;
    count_d = count_q;
    if (tick_o && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
    if (clear_i) begin
      presc_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      count_q <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reflex_test_ctrl.sv
`default_nettype none
// ============================================================================
// reflex_test_ctrl : random wait, frame-aligned stimulus, ms brake timing and
//                    best-of-session tracking for the reflex-test simulator.
// Rev 1.0
// ============================================================================
module reflex_test_ctrl
  import reflex_pkg::*;
#(
  parameter int MS_DIV       = 25000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11,
  parameter int TIMEOUT_MS   = 2000,
  parameter int ROUNDS       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_brake,
  input  logic        i_vsync,
  output logic        o_busy,
  output logic        o_stim,
  output logic        o_result_valid,
  output logic [13:0] o_reaction_ms,
  output logic        o_early,
  output logic        o_timeout,
  output logic [3:0]  o_round,
  output logic [13:0] o_best_ms,
  output logic        o_session_done
);

  localparam logic [c_ms_w-1:0] c_timeout    = c_ms_w'(TIMEOUT_MS);
  localparam logic [c_ms_w-1:0] c_min_delay  = c_ms_w'(MIN_DELAY_MS);
  localparam logic [3:0]        c_last_round = 4'(ROUNDS - 1);

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q;
  logic              vsync_q, vs_edge_q;
  logic [c_ms_w-1:0] target_q, target_d;
  logic [c_ms_w-1:0] reaction_q, reaction_d;
  logic [c_ms_w-1:0] best_q, best_d;
  logic [3:0]        round_q, round_d;
  logic              early_q, early_d, timeout_q, timeout_d;
  logic              valid_q, valid_d, done_q, done_d;
  logic              busy_q, stim_q;
  logic              w_clear, w_tick;
  logic [c_ms_w-1:0] w_ms_cnt, w_ms_now;

  assign w_clear = (state_d != state_q);

  ms_timer #(.MS_DIV(MS_DIV)) u_ms_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (w_clear),
    .tick_o  (w_tick),
    .count_o (w_ms_cnt)
  );

  // Count including this cycle's tick: an event sampled k cycles after state
  // entry reads floor(k / MS_DIV).
  assign w_ms_now = (w_tick && (w_ms_cnt != '1)) ? w_ms_cnt + 1'b1 : w_ms_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q    <= c_lfsr_seed;
      vsync_q   <= 1'b0;
      vs_edge_q <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_step(lfsr_q);
      vsync_q   <= i_vsync;
      vs_edge_q <= i_vsync & ~vsync_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    round_d    = round_q;
    best_d     = best_q;
    reaction_d = reaction_q;
    early_d    = early_q;
    timeout_d  = timeout_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          round_d = '0;
          best_d  = c_ms_none;
          state_d = ST_ARM;
        end
      end
      ST_ARM, ST_SYNC: begin
        // A brake before the stimulus aborts the whole session.
        if (i_brake) begin
          reaction_d = '0;
          early_d    = 1'b1;
          timeout_d  = 1'b0;
          valid_d    = 1'b1;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end else if ((state_q == ST_ARM) && (w_ms_now == target_q)) begin
          state_d = ST_SYNC;
        end else if ((state_q == ST_SYNC) && vs_edge_q) begin
          state_d = ST_STIM;
        end
      end
      ST_STIM: begin
        if (i_brake || (w_ms_now >= c_timeout)) begin
          reaction_d = i_brake ? w_ms_now : c_timeout;
          early_d    = 1'b0;
          timeout_d  = ~i_brake;
          valid_d    = 1'b1;
          done_d     = (round_q == c_last_round);
          state_d    = ST_RESULT;
          if (i_brake && (w_ms_now < best_q)) begin
            best_d = w_ms_now;
          end
        end
      end
      ST_RESULT: begin
        if (round_q == c_last_round) begin
          state_d = ST_IDLE;
        end else begin
          round_d = round_q + 1'b1;
          state_d = ST_ARM;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_d == ST_ARM) && (state_q != ST_ARM)) begin
      target_d = c_min_delay + c_ms_w'(lfsr_q[RAND_BITS-1:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q   <= '0;
      round_q    <= '0;
      best_q     <= c_ms_none;
      reaction_q <= '0;
      early_q    <= 1'b0;
      timeout_q  <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      stim_q     <= 1'b0;
    end else begin
      target_q   <= target_d;
      round_q    <= round_d;
      best_q     <= best_d;
      reaction_q <= reaction_d;
      early_q    <= early_d;
      timeout_q  <= timeout_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      busy_q     <= (state_d != ST_IDLE);
      stim_q     <= (state_d == ST_STIM);
    end
  end

  assign o_busy         = busy_q;
  assign o_stim         = stim_q;
  assign o_result_valid = valid_q;
  assign o_reaction_ms  = reaction_q;
  assign o_early        = early_q;
  assign o_timeout      = timeout_q;
  assign o_round        = round_q;
  assign o_best_ms      = best_q;
  assign o_session_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_reflex_test_ctrl.sv
`default_nettype none
// ============================================================================
// tb_reflex_test_ctrl : directed and randomized sessions against a
//                       session-level reference model.
// Rev 1.0
// ============================================================================
module tb_reflex_test_ctrl;

  localparam int MS_DIV = 4;
  localparam int MIN_MS = 3;
  localparam int RBITS  = 2;
  localparam int TO_MS  = 10;
  localparam int ROUNDS = 2;
  localparam int VS_PER = 50;

  logic        clk = 1'b0;
  logic        rst, i_start, i_brake, i_vsync;
  logic        o_busy, o_stim, o_result_valid, o_early, o_timeout, o_session_done;
  logic [13:0] o_reaction_ms, o_best_ms;
  logic [3:0]  o_round;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic [15:0] lfsr_m, lfsr_pre;
  int          arm_at, target_m, round_m, best_m;
  bit          vsync_en = 1'b0;
  int          stim_hits, busy_hits, st;
  bit          aborted;

  reflex_test_ctrl #(
    .MS_DIV(MS_DIV), .MIN_DELAY_MS(MIN_MS), .RAND_BITS(RBITS),
    .TIMEOUT_MS(TO_MS), .ROUNDS(ROUNDS)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_brake(i_brake), .i_vsync(i_vsync),
    .o_busy(o_busy), .o_stim(o_stim), .o_result_valid(o_result_valid),
    .o_reaction_ms(o_reaction_ms), .o_early(o_early), .o_timeout(o_timeout),
    .o_round(o_round), .o_best_ms(o_best_ms), .o_session_done(o_session_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  // Inputs set before a call are sampled at the coming edge; outputs are read 1 ns after it.
  task automatic tick();
    i_vsync  = vsync_en && (((cyc + 1) % VS_PER) == 0);
    lfsr_pre = lfsr_m;
    @(posedge clk);
    #1;
    cyc++;
    lfsr_m  = lfsr_next(lfsr_m);
    i_start = 1'b0;
    i_brake = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_busy"},     32'(o_busy), 0);
    check_val({tag, "_stim"},     32'(o_stim), 0);
    check_val({tag, "_valid"},    32'(o_result_valid), 0);
    check_val({tag, "_early"},    32'(o_early), 0);
    check_val({tag, "_timeout"},  32'(o_timeout), 0);
    check_val({tag, "_done"},     32'(o_session_done), 0);
    check_val({tag, "_reaction"}, 32'(o_reaction_ms), 0);
    check_val({tag, "_round"},    32'(o_round), 0);
    check_val({tag, "_best"},     32'(o_best_ms), 32'h3FFF);
  endtask

  // Expected edge at which o_stim is first seen high: the wait of target_m ms
  // elapses, then the first vsync edge at or after that point, plus one edge.
  function automatic int stim_at();
    int sync_t, v;
    sync_t = arm_at + target_m * MS_DIV;
    v      = ((sync_t + VS_PER - 1) / VS_PER) * VS_PER;
    return v + 1;
  endfunction

  function automatic int new_target(input logic [15:0] l);
    return MIN_MS + (int'(l) % (1 << RBITS));
  endfunction

  task automatic start_session();
    i_start = 1'b1;
    tick();
    arm_at   = cyc;
    target_m = new_target(lfsr_pre);
    round_m  = 0;
    best_m   = 32'h3FFF;
    check_val("busy_rise", 32'(o_busy), 1);
    check_val("round_clear", 32'(o_round), 0);
    check_val("best_clear", 32'(o_best_ms), 32'h3FFF);
  endtask

  // k = 1..40: brake k cycles after o_stim rise; k = 0: no brake (timeout).
  task automatic stim_round(input int k);
    int  stim_t, lim, exp_r;
    bit  exp_to, last, pre_stim, pre_valid;
    stim_t    = stim_at();
    pre_stim  = 1'b0;
    pre_valid = 1'b0;
    while (cyc < stim_t) begin
      tick();
      if ((cyc < stim_t) && (o_stim || o_result_valid)) pre_stim = 1'b1;
    end
    check_val("stim_not_early", 32'(pre_stim), 0);
    check_val("stim_rise", 32'(o_stim), 1);
    lim = (k == 0) ? TO_MS * MS_DIV : k;
    for (int j = 1; j <= lim; j++) begin
      if (j == k) i_brake = 1'b1;
      tick();
      if ((j < lim) && (o_result_valid || !o_stim)) pre_valid = 1'b1;
    end
    exp_to = (k == 0);
    exp_r  = exp_to ? TO_MS : k / MS_DIV;
    last   = (round_m == ROUNDS - 1);
    check_val("no_early_result", 32'(pre_valid), 0);
    check_val("result_valid", 32'(o_result_valid), 1);
    check_val("reaction", 32'(o_reaction_ms), exp_r);
    check_val("timeout_flag", 32'(o_timeout), 32'(exp_to));
    check_val("early_flag", 32'(o_early), 0);
    check_val("stim_fall", 32'(o_stim), 0);
    check_val("done_pulse", 32'(o_session_done), 32'(last));
    if (!exp_to && (exp_r < best_m)) best_m = exp_r;
    tick();
    check_val("valid_one_cycle", 32'(o_result_valid), 0);
    check_val("best", 32'(o_best_ms), best_m);
    check_val("reaction_held", 32'(o_reaction_ms), exp_r);
    if (last) begin
      check_val("busy_end", 32'(o_busy), 0);
    end else begin
      round_m++;
      arm_at   = cyc;
      target_m = new_target(lfsr_pre);
      check_val("round_next", 32'(o_round), round_m);
      check_val("busy_held", 32'(o_busy), 1);
    end
  endtask

  // Brake k cycles after ARM entry, k in 1 .. stim_at()-arm_at.
  task automatic early_round(input int k);
    bit pre_valid;
    pre_valid = 1'b0;
    for (int j = 1; j <= k; j++) begin
      if (j == k) i_brake = 1'b1;
      tick();
      if ((j < k) && (o_result_valid || o_stim)) pre_valid = 1'b1;
    end
    check_val("early_no_pre", 32'(pre_valid), 0);
    check_val("early_valid", 32'(o_result_valid), 1);
    check_val("early_flag_set", 32'(o_early), 1);
    check_val("early_reaction", 32'(o_reaction_ms), 0);
    check_val("early_timeout", 32'(o_timeout), 0);
    check_val("early_done", 32'(o_session_done), 1);
    check_val("early_busy", 32'(o_busy), 0);
    check_val("early_stim", 32'(o_stim), 0);
    check_val("early_best", 32'(o_best_ms), best_m);
    check_val("early_round_idx", 32'(o_round), round_m);
    tick();
    check_val("early_done_one_cycle", 32'(o_session_done), 0);
    check_val("early_flag_held", 32'(o_early), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_start = 1'b0; i_brake = 1'b0; i_vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0; lfsr_m = 16'hACE1; vsync_en = 1'b1;

    stim_hits = 0; busy_hits = 0;
    repeat (100) begin
      tick();
      if (o_stim) stim_hits++;
      if (o_busy) busy_hits++;
    end
    check_val("idle_stim", stim_hits, 0);
    check_val("idle_busy", busy_hits, 0);
    check_val("idle_best", 32'(o_best_ms), 32'h3FFF);

    start_session();
    stim_round(21);
    stim_round(9);

    start_session();
    early_round(5);

    start_session();
    stim_round(0);
    stim_round(TO_MS * MS_DIV);

    // Brake on the very edge the vsync would promote SYNC to STIM.
    start_session();
    stim_round(7);
    early_round(stim_at() - arm_at);

    start_session();
    i_start = 1'b1;
    tick();
    check_val("start_ignored_r0", 32'(o_round), 0);
    check_val("start_ignored_busy", 32'(o_busy), 1);
    stim_round(13);
    i_start = 1'b1;
    tick();
    check_val("start_ignored_r1", 32'(o_round), 1);
    stim_round(20);

    start_session();
    st = stim_at();
    while (cyc < st + 5) tick();
    check_val("stim_before_rst", 32'(o_stim), 1);
    #3;
    rst = 1'b1;
    #1;
    check_val("stim_async_drop", 32'(o_stim), 0);
    check_reset("mid_rst");
    vsync_en = 1'b0;
    i_vsync  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; lfsr_m = 16'hACE1; vsync_en = 1'b1;

    start_session();
    stim_round(5);
    stim_round(33);

    repeat (20) begin
      repeat ($urandom_range(0, 30)) tick();
      start_session();
      aborted = 1'b0;
      for (int r = 0; r < ROUNDS; r++) begin
        if (!aborted) begin
          if ($urandom_range(0, 4) == 0) begin
            early_round(int'($urandom_range(1, stim_at() - arm_at)));
            aborted = 1'b1;
          end else begin
            stim_round(int'($urandom_range(0, TO_MS * MS_DIV)));
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reflex_test_ctrl.md
# reflex_test_ctrl

Sequencer for the reflex-test simulator. It schedules a pseudo-random wait, then raises a frame-aligned stimulus that the VGA circle renderer shows as a colour change. It measures the driver's brake response in milliseconds and runs a multi-round session tracking the best time. It sits between the debounced push-button and brake inputs and the 640x480 renderer, consuming the renderer's vsync.

## Interface
Parameters:
- `MS_DIV`, 25000: clk cycles per millisecond at 25 MHz.
- `MIN_DELAY_MS`, 1000: fixed part of the random wait.
- `RAND_BITS`, 11: LFSR bits added to the wait (0..2047 ms).
- `TIMEOUT_MS`, 2000: maximum reaction window.
- `ROUNDS`, 5: tests per session (1..15).

Ports:
- `clk` in 1: 25 MHz pixel clock.
- `rst` in 1: asynchronous, active-high reset.
- `i_start` in 1: one-cycle pulse (debounced) to begin a session.
- `i_brake` in 1: one-cycle pulse (debounced) for the driver response.
- `i_vsync` in 1: renderer vsync, active-high pulse at frame start.
- `o_busy` out 1: session in progress.
- `o_stim` out 1: stimulus active; the renderer switches the circle palette.
- `o_result_valid` out 1: one-cycle pulse when a round ends.
- `o_reaction_ms` out 14: result of the last round, held until the next result.
- `o_early` out 1: with `o_result_valid`, brake arrived before the stimulus.
- `o_timeout` out 1: with `o_result_valid`, no brake within `TIMEOUT_MS`.
- `o_round` out 4: current round index, 0-based.
- `o_best_ms` out 14: minimum valid reaction time in the session.
- `o_session_done` out 1: one-cycle pulse after the final round or an abort.

## Operation
- Millisecond prescaler: 0..`MS_DIV`-1. It is cleared on every state transition. `ms_tick` fires when the prescaler equals `MS_DIV`-1. The ms counter (14 bit, saturating at 16383) is cleared on state entry and increments on `ms_tick`.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, reset seed 16'hACE1. It steps every clk and never reaches zero.
- Wait target is `MIN_DELAY_MS` + `lfsr[RAND_BITS-1:0]`, latched on entry to ARM.
- vsync rising edge is detected from a registered copy of `i_vsync`.
- FSM states:
  - IDLE: on `i_start`, clear round to 0 and set best to 14'h3FFF, then go to ARM.
  - ARM: when ms count equals the target, go to SYNC. On `i_brake`, take the EARLY exit.
  - SYNC: on a vsync rising edge, go to STIM. On `i_brake`, take the EARLY exit.
  - STIM (`o_stim`=1): on `i_brake`, set reaction = ms count and go to RESULT. If ms count reaches `TIMEOUT_MS` with no brake, set reaction = `TIMEOUT_MS`, set timeout, and go to RESULT.
  - RESULT (one cycle): pulse `o_result_valid`. If valid and reaction < best, update best.
    - If round = `ROUNDS`-1, pulse `o_session_done` and go to IDLE.
    - Otherwise increment round and go to ARM.
  - EARLY exit: reaction = 0, `o_early`=1, `o_result_valid` and `o_session_done` pulse together, return to IDLE. An early brake aborts the session; best is kept.
- `i_start` outside IDLE is ignored. `i_brake` in IDLE or RESULT is ignored.
- Simultaneous brake and timeout in STIM: the brake wins, reaction = `TIMEOUT_MS`, `o_timeout`=0.
- Simultaneous brake and vsync edge in SYNC: the brake wins (early).
- `o_early` and `o_timeout` are held with `o_reaction_ms` until the next result.

## Timing
- Reset values: `o_busy`, `o_stim`, `o_result_valid`, `o_early`, `o_timeout`, `o_session_done` = 0. `o_reaction_ms` = 0, `o_round` = 0, `o_best_ms` = 14'h3FFF. State is IDLE, LFSR is 16'hACE1.
- `rst` mid-session returns immediately to IDLE and drops `o_stim` asynchronously.
- All outputs are registered.
- `o_busy` rises the cycle after `i_start` is sampled.
- `o_stim` rises 2 cycles after the `i_vsync` rising edge (edge-detect register, then state register).
- Reaction time in ms = floor(cycles from `o_stim` rise to `i_brake` sample / `MS_DIV`).
- `o_result_valid` is high the cycle after brake or timeout is detected. `o_stim` falls in that same cycle.
- The next ARM begins the cycle after RESULT, so there is no gap beyond one cycle.

## Structure
- Shared package `reflex_pkg` holds:
  - State encoding: IDLE, ARM, SYNC, STIM, RESULT.
  - The 14-bit ms width.
  - The LFSR seed and taps.
  - The 14'h3FFF "no result" constant.
- One natural sub-module, `ms_timer`: prescaler plus saturating ms counter, with clear input and `ms_tick` output.
- The LFSR stays inline.

## Test plan
Simulation uses `MS_DIV`=4, `MIN_DELAY_MS`=3, `RAND_BITS`=2, `TIMEOUT_MS`=10, `ROUNDS`=2.
- Reset, then idle 100 cycles -> `o_busy`=0, `o_best_ms`=3FFF, `o_stim` never high.
- `i_start`, vsync every 50 cycles, brake 21 cycles after `o_stim` rise -> `o_reaction_ms`=5, `o_early`=0, `o_round` goes to 1.
- Second round, brake 9 cycles after stim -> reaction 2, `o_best_ms`=2, `o_session_done` pulse, `o_busy`=0.
- Brake during ARM -> `o_result_valid`, `o_early`=1, `o_reaction_ms`=0, session done, `o_best_ms` unchanged.
- No brake after stim -> result after 40 cycles, reaction 10, `o_timeout`=1. Brake in the timeout cycle -> `o_timeout`=0, reaction 10.
- `rst` asserted while in STIM -> `o_stim` low immediately, all outputs at reset values. `i_start` while busy -> no effect on `o_round`.
